// File: rtl/watch_time_if.sv
// Button-pulse inputs and time-of-day outputs between the button conditioning
// stage (master) and watch_time_core (slave).
interface watch_time_if #(
  parameter int MSEC_MAX = 100,
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HOUR_MAX = 24
);
  logic                        btn_set;
  logic                        btn_up;
  logic                        btn_down;
  logic [$clog2(MSEC_MAX)-1:0] msec;
  logic [$clog2(SEC_MAX)-1:0]  sec;
  logic [$clog2(MIN_MAX)-1:0]  min;
  logic [$clog2(HOUR_MAX)-1:0] hour;
  logic [1:0]                  set_field;
  logic                        tick_100hz;

  modport master (
    output btn_set, btn_up, btn_down,
    input  msec, sec, min, hour, set_field, tick_100hz
  );

  modport slave (
    input  btn_set, btn_up, btn_down,
    output msec, sec, min, hour, set_field, tick_100hz
  );
endinterface

// File: rtl/watch_time_core.sv
// 24-hour time-of-day counter with a self-generated 100 Hz timebase and a
// RUN -> SET_HOUR -> SET_MIN -> SET_SEC set-mode FSM with per-field up/down.
module watch_time_core #(
  parameter int MSEC_MAX    = 100,
  parameter int SEC_MAX     = 60,
  parameter int MIN_MAX     = 60,
  parameter int HOUR_MAX    = 24,
  parameter int COUNT_100HZ = 1_000_000,
  parameter int INIT_HOUR   = 12
) (
  input  logic         clk,
  input  logic         reset,
  watch_time_if.slave  bus
);

  localparam int MSEC_W = $clog2(MSEC_MAX);
  localparam int SEC_W  = $clog2(SEC_MAX);
  localparam int MIN_W  = $clog2(MIN_MAX);
  localparam int HOUR_W = $clog2(HOUR_MAX);
  localparam int TCNT_W = (COUNT_100HZ > 1) ? $clog2(COUNT_100HZ) : 1;

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(COUNT_100HZ - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t              state;
  logic [TCNT_W-1:0]   tcnt;
  logic [TCNT_W-1:0]   tcnt_next;
  logic [MSEC_W-1:0]   msec_q;
  logic [SEC_W-1:0]    sec_q;
  logic [MIN_W-1:0]    min_q;
  logic [HOUR_W-1:0]   hour_q;
  logic                tick_q;

  // Modular +1/-1 on a single field; set-mode edits never carry or borrow.
  function automatic int step_wrap(input int value, input int modulus, input logic up);
    if (up) return (value == modulus - 1) ? 0 : value + 1;
    else    return (value == 0) ? modulus - 1 : value - 1;
  endfunction

  assign tcnt_next = (tcnt == TCNT_LAST) ? '0 : tcnt + 1'b1;

  // NOTE: every state element uses non-blocking assignments so all flops
  // sample pre-edge values; the carry cascade below depends on that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      tcnt   <= '0;
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= HOUR_W'(INIT_HOUR);
      tick_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          tcnt <= tcnt_next;
          // Whole cascade settles on this one edge: no intermediate values.
          if (tick_q) begin
            if (msec_q == MSEC_W'(MSEC_MAX - 1)) begin
              msec_q <= '0;
              if (sec_q == SEC_W'(SEC_MAX - 1)) begin
                sec_q <= '0;
                if (min_q == MIN_W'(MIN_MAX - 1)) begin
                  min_q  <= '0;
                  hour_q <= (hour_q == HOUR_W'(HOUR_MAX - 1)) ? '0 : hour_q + 1'b1;
                end else begin
                  min_q <= min_q + 1'b1;
                end
              end else begin
                sec_q <= sec_q + 1'b1;
              end
            end else begin
              msec_q <= msec_q + 1'b1;
            end
          end
          if (bus.btn_set) begin
            state  <= SET_HOUR;
            tick_q <= 1'b0;
          end else begin
            tick_q <= (tcnt_next == TCNT_LAST);
          end
        end

        default: begin
          tick_q <= 1'b0;
          if (bus.btn_set) begin
            unique case (state)
              SET_HOUR: state <= SET_MIN;
              SET_MIN:  state <= SET_SEC;
              default: begin
                // Back to RUN on a clean second boundary.
                state  <= RUN;
                tcnt   <= '0;
                msec_q <= '0;
                tick_q <= (TCNT_LAST == '0);
              end
            endcase
          end else if (bus.btn_up ^ bus.btn_down) begin
            unique case (state)
              SET_HOUR: hour_q <= HOUR_W'(step_wrap(int'(hour_q), HOUR_MAX, bus.btn_up));
              SET_MIN:  min_q  <= MIN_W'(step_wrap(int'(min_q), MIN_MAX, bus.btn_up));
              default:  sec_q  <= SEC_W'(step_wrap(int'(sec_q), SEC_MAX, bus.btn_up));
            endcase
          end
        end
      endcase
    end
  end

  assign bus.msec       = msec_q;
  assign bus.sec        = sec_q;
  assign bus.min        = min_q;
  assign bus.hour       = hour_q;
  assign bus.set_field  = state;
  assign bus.tick_100hz = tick_q;

endmodule

// File: tb/tb_watch_time_core.sv
// Scoreboard bench for watch_time_core: the reference model keeps time as total
// centiseconds since midnight and predicts every output after every clock edge.
module tb_watch_time_core;

  localparam int C         = 4;
  localparam int INIT_HOUR = 12;
  localparam int DAY_CS    = 24 * 60 * 60 * 100;

  typedef struct packed {
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] sf;
    logic       tick;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  watch_time_if #(.MSEC_MAX(100), .SEC_MAX(60), .MIN_MAX(60), .HOUR_MAX(24)) bus ();

  watch_time_core #(
    .MSEC_MAX(100), .SEC_MAX(60), .MIN_MAX(60), .HOUR_MAX(24),
    .COUNT_100HZ(C), .INIT_HOUR(INIT_HOUR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  obs_t exp_q[$];

  // Reference model: time of day as centiseconds, set mode as 0..3, phase in timebase.
  int m_total, m_mode, m_phase;
  bit m_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.msec = bus.msec;
    o.sec  = bus.sec;
    o.min  = bus.min;
    o.hour = bus.hour;
    o.sf   = bus.set_field;
    o.tick = bus.tick_100hz;
    return o;
  endfunction

  function automatic obs_t predict();
    obs_t o;
    o.msec = 7'(m_total % 100);
    o.sec  = 6'((m_total / 100) % 60);
    o.min  = 6'((m_total / 6000) % 60);
    o.hour = 5'(m_total / 360000);
    o.sf   = 2'(m_mode);
    o.tick = m_tick;
    return o;
  endfunction

  task automatic model_reset();
    m_total = INIT_HOUR * 360000;
    m_mode  = 0;
    m_phase = 0;
    m_tick  = (C == 1);
  endtask

  task automatic model_step(input bit s, input bit u, input bit d);
    int h, mi, se, cs, dl;
    if (m_mode == 0) begin
      if (m_tick) m_total = (m_total + 1) % DAY_CS;
      m_phase = (m_phase + 1) % C;
      if (s) m_mode = 1;
    end else if (s) begin
      if (m_mode == 3) begin
        m_mode  = 0;
        m_phase = 0;
        m_total = m_total - (m_total % 100);
      end else begin
        m_mode = m_mode + 1;
      end
    end else if (u != d) begin
      h  = m_total / 360000;
      mi = (m_total / 6000) % 60;
      se = (m_total / 100) % 60;
      cs = m_total % 100;
      dl = u ? 1 : -1;
      case (m_mode)
        1:       h  = (h + dl + 24) % 24;
        2:       mi = (mi + dl + 60) % 60;
        default: se = (se + dl + 60) % 60;
      endcase
      m_total = ((h * 60 + mi) * 60 + se) * 100 + cs;
    end
    m_tick = (m_mode == 0) && (m_phase == C - 1);
  endtask

  task automatic drive_and_push(input bit s, input bit u, input bit d);
    bus.btn_set  = s;
    bus.btn_up   = u;
    bus.btn_down = d;
    model_step(s, u, d);
    exp_q.push_back(predict());
  endtask

  // One clock: drive at negedge, let the edge and the monitor pass.
  task automatic step(input bit s, input bit u, input bit d);
    @(negedge clk);
    drive_and_push(s, u, d);
    @(posedge clk);
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    drive_and_push(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
  endtask

  // Asserted between edges; outputs must change with no clock edge.
  task automatic assert_reset();
    #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    model_reset();
    check("async_reset", 32'(observe()), 32'(predict()));
    check("async_reset_hour", 32'(bus.hour), 32'(INIT_HOUR));
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: DUT output with no expected entry at %0t", $time);
      end else begin
        check("cycle", 32'(observe()), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    reset        = 1'b1;
    bus.btn_set  = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    #1;
    model_reset();
    check("reset_state", 32'(observe()), 32'(predict()));
    check("reset_hour", 32'(bus.hour), 32'(INIT_HOUR));

    // Free run 400 cycles: 100 ticks, one second elapsed.
    release_reset();
    ticks = bus.tick_100hz ? 1 : 0;
    repeat (399) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.tick_100hz) ticks++;
    end
    check("ticks_in_400", 32'(ticks), 32'd100);
    check("run_msec", 32'(bus.msec), 32'd0);
    check("run_sec", 32'(bus.sec), 32'd1);
    check("run_hour", 32'(bus.hour), 32'd12);

    // SET_HOUR, 13 decrements from 12 wraps to 23.
    step(1'b1, 1'b0, 1'b0);
    repeat (13) step(1'b0, 1'b0, 1'b1);
    check("set_hour_23", 32'(bus.hour), 32'd23);
    check("set_field_hour", 32'(bus.set_field), 32'd1);
    check("set_hour_min", 32'(bus.min), 32'd0);
    check("set_hour_sec", 32'(bus.sec), 32'd1);

    // SET_MIN wrap without carry, then up+down together.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("min_down_wrap", 32'(bus.min), 32'd59);
    step(1'b0, 1'b1, 1'b0);
    check("min_up_wrap", 32'(bus.min), 32'd0);
    check("min_wrap_hour", 32'(bus.hour), 32'd23);
    step(1'b0, 1'b1, 1'b1);
    check("up_down_nop", 32'(bus.min), 32'd0);
    step(1'b0, 1'b0, 1'b1);

    // SET_SEC 1 -> 59, back to RUN at 23:59:59.00.
    step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    check("sec_59", 32'(bus.sec), 32'd59);
    step(1'b1, 1'b0, 1'b0);
    check("back_to_run", 32'(bus.set_field), 32'd0);
    repeat (399) step(1'b0, 1'b0, 1'b0);
    check("pre_roll_msec", 32'(bus.msec), 32'd99);
    check("pre_roll_hms", 32'({bus.hour, bus.min, bus.sec}), 32'({5'd23, 6'd59, 6'd59}));
    step(1'b0, 1'b0, 1'b0);
    check("midnight_roll", 32'({bus.hour, bus.min, bus.sec, bus.msec}), 32'd0);

    // btn_set with btn_up in SET_SEC: state wins, timebase restarts.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("in_set_sec", 32'(bus.set_field), 32'd3);
    step(1'b1, 1'b1, 1'b0);
    check("set_wins_state", 32'(bus.set_field), 32'd0);
    check("set_wins_sec", 32'(bus.sec), 32'd0);
    check("set_wins_msec", 32'(bus.msec), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("restart_tick1", 32'(bus.tick_100hz), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("restart_tick2", 32'(bus.tick_100hz), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("restart_tick3", 32'(bus.tick_100hz), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("restart_msec", 32'(bus.msec), 32'd1);

    // Reset in the middle of SET_MIN at 05:33.
    step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (33) step(1'b0, 1'b1, 1'b0);
    check("preset_hm", 32'({bus.hour, bus.min}), 32'({5'd5, 6'd33}));
    check("preset_field", 32'(bus.set_field), 32'd2);
    assert_reset();
    release_reset();

    // Randomized buttons against the model.
    repeat (3000) begin
      step($urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);
    end
    step(1'b0, 1'b0, 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/watch_time_core.md
# watch_time_core

Time-of-day counter and time-set state machine that produces the `msec`/`sec`/`min`/`hour` binary fields consumed by the FND display controller. It sits directly upstream of the display stage, between the debounced button pulses and the 7-segment multiplexer. It generates its own 100 Hz timebase from the system clock, keeps 24-hour time with full carry cascading, and supports a three-field set mode with up/down adjustment.

## Interface
- `MSEC_MAX`, 100, centisecond modulus
- `SEC_MAX`, 60, second modulus
- `MIN_MAX`, 60, minute modulus
- `HOUR_MAX`, 24, hour modulus
- `COUNT_100HZ`, 1_000_000, clk cycles per centisecond tick; benches use a small value
- `INIT_HOUR`, 12, hour value loaded at reset; must be < HOUR_MAX

Ports:
- `clk`  in  1  system clock (100 MHz)
- `reset`  in  1  reset, asynchronous, active-high
- `btn_set`  in  1  single-cycle pulse; advances the set-mode FSM
- `btn_up`  in  1  single-cycle pulse; increments the selected field in set mode
- `btn_down`  in  1  single-cycle pulse; decrements the selected field in set mode
- `msec`  out  $clog2(MSEC_MAX)  centiseconds, registered
- `sec`  out  $clog2(SEC_MAX)  seconds, registered
- `min`  out  $clog2(MIN_MAX)  minutes, registered
- `hour`  out  $clog2(HOUR_MAX)  hours, registered
- `set_field`  out  2  0 = run, 1 = hour, 2 = min, 3 = sec; registered; drives display blink
- `tick_100hz`  out  1  one-cycle timebase pulse; forced low in set mode

## Operation
- The timebase counter `tcnt` counts 0..COUNT_100HZ-1 and wraps.
  - `tick_100hz` is high for exactly the cycle in which `tcnt == COUNT_100HZ-1` and state is RUN.
- The FSM has four states: RUN → SET_HOUR → SET_MIN → SET_SEC → RUN. It advances on each `btn_set` pulse. `set_field` encodes the state as 0/1/2/3.
- RUN:
  - On each edge where `tick_100hz` is high, `msec` increments.
  - `msec` wraps MSEC_MAX-1 → 0 and carries to `sec`. `sec` wraps SEC_MAX-1 → 0 and carries to `min`. `min` wraps MIN_MAX-1 → 0 and carries to `hour`. `hour` wraps HOUR_MAX-1 → 0.
  - The whole cascade resolves on a single edge; no field is ever observed holding an out-of-range or intermediate value.
  - `btn_up` and `btn_down` are ignored.
- SET_* states:
  - `tcnt` and `msec` are frozen; no carries occur.
  - `btn_up` increments only the selected field. It wraps MAX-1 → 0 with no carry into other fields.
  - `btn_down` decrements only the selected field. It wraps 0 → MAX-1 with no borrow.
- Leaving SET_SEC for RUN clears `tcnt` and `msec` to 0 on the same edge as the state change. Counting therefore restarts from a clean second.
- Simultaneous events:
  - `btn_set` with `btn_up` or `btn_down`: `btn_set` wins, the state advances, and the field is not modified.
  - `btn_up` with `btn_down` (no `btn_set`): no change.
- Inputs are treated as synchronous pulses. A level held for N cycles counts as N presses; debouncing and edge-detection are upstream responsibilities.
- Arithmetic: all fields are unsigned binary and compared against MAX-1 explicitly. No BCD is produced here; digit splitting is downstream.

## Timing
- Reset values, applied asynchronously:
  - `msec=0`, `sec=0`, `min=0`, `hour=INIT_HOUR`
  - `tcnt=0`, state RUN, `set_field=0`, `tick_100hz=0`
- After reset release, the first `tick_100hz` occurs on cycle COUNT_100HZ, with cycle 1 being the first rising edge after release. `msec` reads 1 after that edge.
- `msec` then advances every COUNT_100HZ cycles.
- Button latency: a pulse sampled at edge k updates the field or state at edge k, so the output is visible in the cycle after the pulse.
- In set mode, `tick_100hz` stays 0 and `tcnt` holds its value.
- Reset mid-set returns to RUN with reset values. Any partially set time is discarded.
- All outputs are driven directly from flops, with no combinational path from inputs to outputs.

## Test plan
All scenarios use COUNT_100HZ=4.
- Reset then free-run 400 cycles → `msec` reaches 100 wraps = 0, `sec=1`, `hour=12`; `tick_100hz` seen every 4th cycle.
- Preload via set mode to 23:59:59, return to RUN, run 400 cycles → exactly at the 100th tick all fields read 00:00:00.00 on one edge.
- `btn_set` ×1, `btn_down` ×13 at hour 12 → `hour=23`; `set_field=1`; `min`/`sec` unchanged.
- In SET_MIN at min=59, `btn_up` → `min=0`, `hour` unchanged; `btn_up` and `btn_down` asserted together → no change.
- `btn_set` together with `btn_up` in SET_SEC → state RUN, `sec` unchanged, `msec=0`, `tcnt=0`; next tick after 4 cycles.
- Assert `reset` mid-SET_MIN with time 05:33 → outputs return to 12:00:00.00 with `set_field=0` immediately, without waiting for a clock edge.
